// File: rtl/ascon_round_sequencer_pkg.sv
// Shared types and constants for the Ascon permutation control path.
// Holds the sequencer state enum, round sizing and the round-constant table.
package ascon_pack;

  localparam int MAX_ROUNDS_C = 12;
  localparam int ROUND_IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } type_seq_state;

  // Round constant added to x2 in round i of the 12-round permutation.
  function automatic logic [7:0] round_constant(input logic [ROUND_IDX_W-1:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd0:    rc = 8'hf0;
      4'd1:    rc = 8'he1;
      4'd2:    rc = 8'hd2;
      4'd3:    rc = 8'hc3;
      4'd4:    rc = 8'hb4;
      4'd5:    rc = 8'ha5;
      4'd6:    rc = 8'h96;
      4'd7:    rc = 8'h87;
      4'd8:    rc = 8'h78;
      4'd9:    rc = 8'h69;
      4'd10:   rc = 8'h5a;
      4'd11:   rc = 8'h4b;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/ascon_round_sequencer_if.sv
// Handshake bundle between the mode FSM (master) and the round sequencer (slave).
// ASCON_SEQ_ERR_EN adds the err_o rejection pulse.
interface ascon_round_sequencer_if;
  import ascon_pack::*;

  logic                   start_i;
  logic [ROUND_IDX_W-1:0] nb_rounds_i;
  logic [ROUND_IDX_W-1:0] round_o;
  logic                   en_round_o;
  logic                   init_o;
  logic                   busy_o;
  logic                   done_o;
`ifdef ASCON_SEQ_ERR_EN
  logic                   err_o;
`endif

  modport slave (
    input  start_i,
    input  nb_rounds_i,
    output round_o,
    output en_round_o,
    output init_o,
    output busy_o,
`ifdef ASCON_SEQ_ERR_EN
    output err_o,
`endif
    output done_o
  );

  modport master (
    output start_i,
    output nb_rounds_i,
    input  round_o,
    input  en_round_o,
    input  init_o,
    input  busy_o,
`ifdef ASCON_SEQ_ERR_EN
    input  err_o,
`endif
    input  done_o
  );

endinterface

// File: rtl/ascon_round_sequencer_counter.sv
// Loadable round-index up-counter. Saturates at MAX_ROUNDS-1 so the
// index handed to the constant adder can never wrap.
module ascon_round_counter
  import ascon_pack::*;
#(
  parameter int MAX_ROUNDS = MAX_ROUNDS_C
) (
  input  logic                   clock_i,
  input  logic                   resetb_i,
  input  logic                   load_i,
  input  logic [ROUND_IDX_W-1:0] load_value_i,
  input  logic                   en_i,
  output logic [ROUND_IDX_W-1:0] count_o,
  output logic                   last_o
);

  localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(MAX_ROUNDS - 1);

  logic [ROUND_IDX_W-1:0] count_q, count_d;

  assign last_o  = (count_q == LAST_IDX);
  assign count_o = count_q;

  // Load wins over increment; increment stops at the terminal index.
  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_value_i;
    else if (en_i && !last_o)
      count_d = count_q + 1'b1;
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) count_q <= '0;
    else           count_q <= count_d;
  end

endmodule

// File: rtl/ascon_round_sequencer.sv
// Ascon round sequencer: turns a start request with a round count into a
// run of round indices ending at MAX_ROUNDS-1, then a one-cycle done pulse.
// Optional macro ASCON_SEQ_ERR_EN: reject illegal counts with an err_o pulse
// instead of ignoring n=0 and clamping n>MAX_ROUNDS.
module ascon_round_sequencer
  import ascon_pack::*;
#(
  parameter int MAX_ROUNDS = MAX_ROUNDS_C
) (
  input  logic                    clock_i,
  input  logic                    resetb_i,
  ascon_round_sequencer_if.slave  seq_if
);

  localparam logic [ROUND_IDX_W-1:0] MAX_R = ROUND_IDX_W'(MAX_ROUNDS);

  type_seq_state          state_q;
  logic                   init_q, en_q, busy_q, done_q;
  logic                   n_zero, n_over, accept;
  logic [ROUND_IDX_W-1:0] first_idx, cnt_load_val, round_idx;
  logic                   cnt_load, cnt_en, cnt_last;
`ifdef ASCON_SEQ_ERR_EN
  logic                   reject, err_q;
`endif

  // Start decode: legality of n and the first round index of the run.
  always_comb begin
    n_zero    = (seq_if.nb_rounds_i == '0);
    n_over    = (seq_if.nb_rounds_i > MAX_R);
    first_idx = MAX_R - seq_if.nb_rounds_i;
`ifdef ASCON_SEQ_ERR_EN
    accept    = (state_q == IDLE) && seq_if.start_i && !n_zero && !n_over;
    reject    = (state_q == IDLE) && seq_if.start_i && (n_zero || n_over);
`else
    accept    = (state_q == IDLE) && seq_if.start_i && !n_zero;
    if (n_over) first_idx = '0;  // clamp to a full-length run
`endif
  end

  // Counter loads the first index on accept and returns to 0 when leaving DONE.
  assign cnt_load     = accept || (state_q == DONE);
  assign cnt_load_val = accept ? first_idx : '0;
  assign cnt_en       = (state_q == RUN);

  ascon_round_counter #(.MAX_ROUNDS(MAX_ROUNDS)) u_cnt (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .load_i       (cnt_load),
    .load_value_i (cnt_load_val),
    .en_i         (cnt_en),
    .count_o      (round_idx),
    .last_o       (cnt_last)
  );

  // IDLE -> RUN -> DONE -> IDLE with all control outputs registered.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ASCON_SEQ_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef ASCON_SEQ_ERR_EN
      err_q <= reject;
`endif
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q <= RUN;
            init_q  <= 1'b1;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          init_q <= 1'b0;
          if (cnt_last) begin
            state_q <= DONE;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          init_q  <= 1'b0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign seq_if.round_o    = round_idx;
  assign seq_if.en_round_o = en_q;
  assign seq_if.init_o     = init_q;
  assign seq_if.busy_o     = busy_q;
  assign seq_if.done_o     = done_q;
`ifdef ASCON_SEQ_ERR_EN
  assign seq_if.err_o      = err_q;
`endif

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Scoreboard bench for ascon_round_sequencer: stimulus pushes the expected
// per-cycle output records, a negedge monitor pops and compares them on every
// cycle the DUT shows activity.
module tb_ascon_round_sequencer;

  logic clock_i  = 1'b0;
  logic resetb_i = 1'b1;
  int   cyc      = 0;
  int   n_tot    = 0;
  int   n_pass   = 0;

  ascon_round_sequencer_if sif();

  ascon_round_sequencer dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .seq_if   (sif)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;

  logic err_s;
`ifdef ASCON_SEQ_ERR_EN
  assign err_s = sif.err_o;
`else
  assign err_s = 1'b0;
`endif

  typedef struct {
    int round;
    int init;
    int en;
    int done;
    int busy;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   init_times[$];
  exp_t mon_e;

  task automatic check(input string name, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Expected records for one start request with count n.
  task automatic push_run(input int n);
    int nn;
    nn = n;
`ifdef ASCON_SEQ_ERR_EN
    if (nn == 0 || nn > 12) begin
      exp_q.push_back('{round: 0, init: 0, en: 0, done: 0, busy: 0, err: 1});
      return;
    end
`else
    if (nn == 0) return;
    if (nn > 12) nn = 12;
`endif
    for (int i = 0; i < nn; i++)
      exp_q.push_back('{round: 12 - nn + i, init: (i == 0), en: 1, done: 0, busy: 1, err: 0});
    exp_q.push_back('{round: 11, init: 0, en: 0, done: 1, busy: 1, err: 0});
  endtask

  // Monitor: every active cycle must match the head of the scoreboard.
  always @(negedge clock_i) begin
    if (resetb_i && (sif.en_round_o || sif.done_o || sif.busy_o || err_s)) begin
      if (sif.init_o) init_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_activity", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("round_o",    int'(sif.round_o),    mon_e.round);
        check("init_o",     int'(sif.init_o),     mon_e.init);
        check("en_round_o", int'(sif.en_round_o), mon_e.en);
        check("done_o",     int'(sif.done_o),     mon_e.done);
        check("busy_o",     int'(sif.busy_o),     mon_e.busy);
        check("err_o",      int'(err_s),          mon_e.err);
      end
    end
  end

  task automatic do_start(input int n);
    @(posedge clock_i); #1;
    sif.start_i     = 1'b1;
    sif.nb_rounds_i = 4'(n);
    push_run(n);
    @(posedge clock_i); #1;
    sif.start_i     = 1'b0;
    sif.nb_rounds_i = 4'd3;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock_i); #2;
      if (exp_q.size() == 0 && !sif.busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_round_o"},    int'(sif.round_o),    0);
    check({tag, "_en_round_o"}, int'(sif.en_round_o), 0);
    check({tag, "_init_o"},     int'(sif.init_o),     0);
    check({tag, "_busy_o"},     int'(sif.busy_o),     0);
    check({tag, "_done_o"},     int'(sif.done_o),     0);
    check({tag, "_err_o"},      int'(err_s),          0);
  endtask

  initial begin
    bit hit;
    sif.start_i     = 1'b0;
    sif.nb_rounds_i = 4'd0;

    // Reset state
    #2 resetb_i = 1'b0;
    #10 check_all_zero("reset");
    #10 resetb_i = 1'b1;

    // Full run: indices 0..11, done on the 13th active cycle
    do_start(12);
    wait_drain("drain_n12");

    // Short run with start and nb_rounds disturbed mid-run
    do_start(6);
    @(posedge clock_i); #1;
    sif.start_i     = 1'b1;
    sif.nb_rounds_i = 4'd2;
    @(posedge clock_i); #1;
    sif.start_i     = 1'b0;
    wait_drain("drain_n6");

    // start held high: second run starts n+2 = 10 cycles after the first
    init_times.delete();
    @(posedge clock_i); #1;
    sif.start_i     = 1'b1;
    sif.nb_rounds_i = 4'd8;
    push_run(8);
    push_run(8);
    repeat (11) @(posedge clock_i);
    #1 sif.start_i  = 1'b0;
    wait_drain("drain_held");
    check("init_count", init_times.size(), 2);
    if (init_times.size() == 2) check("init_spacing", init_times[1] - init_times[0], 10);
    else                        check("init_spacing", -1, 10);

    // Asynchronous reset during round 5 of a full run
    do_start(12);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock_i); #2;
      if (sif.en_round_o && sif.round_o == 4'd5) begin
        hit = 1'b1;
        break;
      end
    end
    check("reached_round5", int'(hit), 1);
    #1 resetb_i = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clock_i);
    #3 resetb_i = 1'b1;
    repeat (15) @(posedge clock_i);
    #2 check("post_reset_busy", int'(sif.busy_o), 0);

    // Illegal counts, then a legal start is still accepted
    do_start(0);
    repeat (6) @(posedge clock_i);
    #2 check("n0_busy", int'(sif.busy_o), 0);
    wait_drain("drain_n0");
    do_start(15);
    wait_drain("drain_n15");
    do_start(13);
    wait_drain("drain_n13");
    do_start(8);
    wait_drain("drain_after_illegal");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
